sigma_delta_decimator: RTL and testbench

Receive-side counterpart of the interpolating DAC chain: a third-order CIC decimator that converts a 1-bit sigma-delta bitstream, such as a modulator loopback or an external ADC modulator, into signed 16-bit PCM samples at 1/DECIM of the bit rate. It sits at the head of the ADC path, ahead of any half-band or compensation stages. It uses the same clk_enable / ce_out strobe convention as the DAC filters.

---
 rtl/sdd_pkg.sv | 17 +
 rtl/cic_comb_stage.sv | 24 ++
 rtl/sigma_delta_decimator.sv | 104 ++++++++++
 tb/tb_sigma_delta_decimator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdd_pkg.sv
// Shared sizing helpers and input-mapping constants for the sigma-delta CIC decimator.
package sdd_pkg;

    // Integrator/comb width that holds the full CIC gain DECIM^ORDER with sign headroom.
    function automatic int unsigned acc_width(input int unsigned decim, input int unsigned order);
        return order * $clog2(decim) + 2;
    endfunction

    function automatic int unsigned out_shift(input int unsigned decim, input int unsigned order,
                                              input int unsigned out_width);
        return order * $clog2(decim) - (out_width - 1);
    endfunction

    localparam int BIT_POS = 1;
    localparam int BIT_NEG = -1;

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: o_y = i_x - previous i_x, with the delay captured only on enable.
module cic_comb_stage #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_y
);

    logic [WIDTH-1:0] r_dly;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dly <= '0;
        end else if (i_en) begin
            r_dly <= i_x;
        end
    end

    assign o_y = i_x - r_dly;

endmodule

// File: rtl/sigma_delta_decimator.sv
// Third-order CIC decimator: 1-bit sigma-delta stream in, saturated signed PCM out at 1/DECIM rate.
module sigma_delta_decimator
    import sdd_pkg::*;
#(
    parameter int unsigned DECIM     = 64,
    parameter int unsigned ORDER     = 3,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_enable,
    input  logic                        input_bit,
    output logic signed [OUT_WIDTH-1:0] output_data,
    output logic                        ce_out
);

    localparam int unsigned ACC_W = acc_width(DECIM, ORDER);
    localparam int unsigned SH    = out_shift(DECIM, ORDER, OUT_WIDTH);
    localparam int unsigned CNT_W = $clog2(DECIM);
    localparam int unsigned SHD_W = ACC_W - SH;

    localparam logic signed [SHD_W-1:0] SAT_HI = SHD_W'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SHD_W-1:0] SAT_LO = SHD_W'(-(longint'(1) <<< (OUT_WIDTH - 1)));

    logic [ACC_W-1:0]               w_x;
    logic [ACC_W-1:0]               r_integ [ORDER];
    logic [CNT_W-1:0]               r_cnt;
    logic                           w_tick;
    logic [ACC_W-1:0]               w_comb  [ORDER+1];
    logic signed [ACC_W-1:0]        w_cic;
    logic signed [SHD_W-1:0]        w_shifted;
    logic signed [OUT_WIDTH-1:0]    w_sat;
    logic signed [OUT_WIDTH-1:0]    r_out;
    logic                           r_ce;

    assign w_x = input_bit ? ACC_W'(BIT_POS) : ACC_W'(BIT_NEG);

    // Pipelined integrators: every stage adds the previous stage's pre-update value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                r_integ[k] <= '0;
            end
        end else if (clk_enable) begin
            r_integ[0] <= r_integ[0] + w_x;
            for (int unsigned k = 1; k < ORDER; k++) begin
                r_integ[k] <= r_integ[k] + r_integ[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clk_enable) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_tick = clk_enable && (r_cnt == CNT_W'(DECIM - 1));

    assign w_comb[0] = r_integ[ORDER-1];

    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        cic_comb_stage #(
            .WIDTH (ACC_W)
        ) u_comb (
            .i_clk   (clk),
            .i_rst_n (reset),
            .i_en    (w_tick),
            .i_x     (w_comb[g]),
            .o_y     (w_comb[g+1])
        );
    end

    assign w_cic     = w_comb[ORDER];
    assign w_shifted = SHD_W'(w_cic >>> SH);

    // With a +/-1 input only +full scale can exceed the range; both bounds kept for safety.
    always_comb begin
        w_sat = w_shifted[OUT_WIDTH-1:0];
        if (w_shifted > SAT_HI) begin
            w_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (w_shifted < SAT_LO) begin
            w_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out <= '0;
            r_ce  <= 1'b0;
        end else begin
            r_ce <= w_tick;
            if (w_tick) begin
                r_out <= w_sat;
            end
        end
    end

    assign output_data = r_out;
    assign ce_out      = r_ce;

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Self-checking bench: CIC decimator against a cumulative-sum / decimated-difference reference.
module tb_sigma_delta_decimator;

    localparam int DECIM = 64;
    localparam int ACC_W = 3 * 6 + 2;
    localparam int SH    = 3 * 6 - 15;

    logic               clk = 1'b0;
    logic               reset;
    logic               clk_enable;
    logic               input_bit;
    logic signed [15:0] output_data;
    logic               ce_out;

    int checks;
    int failures;

    longint             m_s1, m_s2, m_s3;
    longint             m_t [3];
    int                 m_n;
    int                 m_strobes;
    logic signed [15:0] m_out;

    sigma_delta_decimator #(
        .DECIM     (64),
        .ORDER     (3),
        .OUT_WIDTH (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .input_bit   (input_bit),
        .output_data (output_data),
        .ce_out      (ce_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_s3 = 0;
        m_t[0] = 0; m_t[1] = 0; m_t[2] = 0;
        m_n = 0; m_strobes = 0; m_out = '0;
    endtask

    // Drive one clock of stimulus and advance the reference model. The model keeps the
    // triple running sum of the +/-1 sequence and takes its third difference at every
    // DECIM-th enabled sample, wrapped to ACC_W bits, scaled and clamped.
    task automatic step(input logic en, input logic b, output logic exp_ce);
        longint x, c3, y, mask;
        logic   tick;
        clk_enable = en;
        input_bit  = b;
        tick = en && ((m_n % DECIM) == DECIM - 1);
        if (tick) begin
            mask = (longint'(1) <<< ACC_W) - 1;
            c3 = m_s3 - 3 * m_t[0] + 3 * m_t[1] - m_t[2];
            c3 = c3 & mask;
            if (c3 >= (longint'(1) <<< (ACC_W - 1))) c3 = c3 - (longint'(1) <<< ACC_W);
            y = c3 >>> SH;
            if (y > 32767) y = 32767;
            else if (y < -32768) y = -32768;
            m_out = 16'(y);
            m_t[2] = m_t[1]; m_t[1] = m_t[0]; m_t[0] = m_s3;
            m_strobes++;
        end
        if (en) begin
            x = b ? 1 : -1;
            m_s3 += m_s2;
            m_s2 += m_s1;
            m_s1 += x;
            m_n++;
        end
        @(posedge clk);
        #1;
        exp_ce = tick;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clk_enable = 1'b0;
        input_bit = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clk_enable = 1'b1;
        input_bit = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ce_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_ce: got %b expected 0", ce_out);
        end
        checks++;
        if (output_data !== 16'sd0) begin
            failures++;
            $display("FAIL reset_data: got %0d expected 0", output_data);
        end
        reset = 1'b1;
        model_reset();
    endtask

    // Repeating bit pattern, optionally with clk_enable every en_period-th cycle; the pattern
    // advances only on enabled cycles so values match the fully enabled run.
    task automatic test_steady(input string name, input logic [7:0] pat, input int plen,
                               input int en_period, input int steady);
        logic exp_ce, en, b;
        int   cyc, nbits, last_strobe, nsteady;
        apply_reset();
        nbits = 0;
        last_strobe = -1;
        nsteady = 0;
        for (cyc = 0; nbits < 10 * DECIM; cyc++) begin
            en = ((cyc % en_period) == 0);
            b  = pat[plen - 1 - (nbits % plen)];
            step(en, b, exp_ce);
            if (en) nbits++;
            checks++;
            if (ce_out !== exp_ce) begin
                failures++;
                $display("FAIL %s_ce cycle %0d: got %b expected %b", name, cyc, ce_out, exp_ce);
            end
            checks++;
            if (output_data !== m_out) begin
                failures++;
                $display("FAIL %s_data cycle %0d: got %0d expected %0d", name, cyc, output_data, m_out);
            end
            if (exp_ce) begin
                if (last_strobe >= 0) begin
                    checks++;
                    if (cyc - last_strobe != DECIM * en_period) begin
                        failures++;
                        $display("FAIL %s_spacing cycle %0d: got %0d expected %0d",
                                 name, cyc, cyc - last_strobe, DECIM * en_period);
                    end
                end
                last_strobe = cyc;
                if (m_strobes >= 4) begin
                    nsteady++;
                    checks++;
                    if (output_data !== 16'(steady)) begin
                        failures++;
                        $display("FAIL %s_steady strobe %0d: got %0d expected %0d",
                                 name, m_strobes, output_data, steady);
                    end
                end
            end
        end
        checks++;
        if (nsteady != 7) begin
            failures++;
            $display("FAIL %s_nsteady: got %0d expected 7", name, nsteady);
        end
    endtask

    task automatic test_midframe_reset();
        logic exp_ce;
        int   found;
        apply_reset();
        for (int k = 0; k < 3 * DECIM + 37; k++) begin
            step(1'b1, 1'b1, exp_ce);
            checks++;
            if (ce_out !== exp_ce || output_data !== m_out) begin
                failures++;
                $display("FAIL midreset_pre cycle %0d: got ce=%b data=%0d expected ce=%b data=%0d",
                         k, ce_out, output_data, exp_ce, m_out);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (output_data !== 16'sd0 || ce_out !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async: got ce=%b data=%0d expected ce=0 data=0", ce_out, output_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        found = -1;
        for (int k = 1; k <= 3 * DECIM; k++) begin
            step(1'b1, 1'b1, exp_ce);
            if (ce_out === 1'b1) begin
                found = k;
                break;
            end
        end
        checks++;
        if (found != DECIM) begin
            failures++;
            $display("FAIL midreset_first_strobe: got %0d expected %0d enabled cycles", found, DECIM);
        end
    endtask

    // Random bitstream with a fresh ones-density every segment and a random clk_enable.
    task automatic test_random_stream();
        logic exp_ce, en, b;
        int   dens;
        apply_reset();
        dens = 50;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            if ((cyc % 2000) == 0) dens = int'($urandom_range(0, 100));
            en = ($urandom_range(0, 9) < 7);
            b  = (int'($urandom_range(0, 99)) < dens);
            step(en, b, exp_ce);
            checks++;
            if (ce_out !== exp_ce) begin
                failures++;
                $display("FAIL random_ce cycle %0d: got %b expected %b", cyc, ce_out, exp_ce);
            end
            checks++;
            if (output_data !== m_out) begin
                failures++;
                $display("FAIL random_data cycle %0d: got %0d expected %0d", cyc, output_data, m_out);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        clk_enable = 1'b0;
        input_bit = 1'b0;
        model_reset();
        test_reset();
        test_steady("ones",       8'b1,    1, 1,  32767);
        test_steady("zeros",      8'b0,    1, 1, -32768);
        test_steady("alt",        8'b10,   2, 1,      0);
        test_steady("p1110",      8'b1110, 4, 1,  16384);
        test_steady("ones_en2",   8'b1,    1, 2,  32767);
        test_midframe_reset();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
